// File: rtl/pe_pkg.sv
// Shared types and flit layout for the PE dispatch controller.
// Imported by the controller and its destination table.
package pe_pkg;

  localparam int VALID_B   = 70;
  localparam int DATA_B    = 69;
  localparam int DEST_HI   = 68;
  localparam int DEST_LO   = 65;
  localparam int VC_B      = 64;
  localparam int PAYLOAD_W = 64;
  localparam int FLIT_W    = 71;

  localparam logic [3:0] DEFAULT_DEST = 4'b0101;

  typedef struct packed {
    logic                 valid;
    logic                 data;
    logic [3:0]           dest;
    logic                 vc;
    logic [PAYLOAD_W-1:0] payload;
  } flit_t;

  typedef enum logic [1:0] {
    COLLECT,
    EXEC,
    WAIT,
    SEND
  } state_t;

endpackage

// File: rtl/pe_dispatch_ctrl_dest_table.sv
// Runtime-programmable fan-out table: per-entry dest/vc plus active count.
// Writes are gated by the controller so the table is frozen mid-operation.
module pe_dest_table
  import pe_pkg::*;
#(
  parameter int MAX_DEST = 4,
  parameter int IW       = $clog2(MAX_DEST)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic          cfg_we,
  input  logic [IW-1:0] cfg_idx,
  input  logic [3:0]    cfg_dest,
  input  logic          cfg_vc,
  input  logic [IW:0]   cfg_num,
  input  logic [IW-1:0] rd_idx,
  output logic [3:0]    rd_dest,
  output logic          rd_vc,
  output logic [IW:0]   num_dest
);

  localparam logic [IW:0] MAX_N = (IW+1)'(MAX_DEST);

  logic [MAX_DEST-1:0][3:0] dest_q;
  logic [MAX_DEST-1:0]      vc_q;
  logic [IW:0]              num_q;
  logic                     we;
  logic                     num_ok;

  assign we     = cfg_we & wr_en;
  assign num_ok = (cfg_num != '0) && (cfg_num <= MAX_N);

  always_ff @(posedge clk) begin
    if (rst) begin
      dest_q <= {MAX_DEST{DEFAULT_DEST}};
      vc_q   <= '0;
      num_q  <= (IW+1)'(1);
    end else if (we) begin
      dest_q[cfg_idx] <= cfg_dest;
      vc_q[cfg_idx]   <= cfg_vc;
      if (num_ok)
        num_q <= cfg_num;
    end
  end

  assign rd_dest  = dest_q[rd_idx];
  assign rd_vc    = vc_q[rd_idx];
  assign num_dest = num_q;

endmodule

// File: rtl/pe_dispatch_ctrl.sv
// Operand collection, PE start/wait with timeout, and table-driven
// result fan-out between a router local port and a two-operand PE.
module pe_dispatch_ctrl
  import pe_pkg::*;
#(
  parameter int MAX_DEST = 4,
  parameter int TIMEOUT  = 255
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [FLIT_W-1:0]          in_flit,
  output logic                       in_ready,
  output logic [PAYLOAD_W-1:0]       pe_op_a,
  output logic [PAYLOAD_W-1:0]       pe_op_b,
  output logic                       pe_start,
  input  logic [PAYLOAD_W-1:0]       pe_result,
  input  logic                       pe_done,
  output logic [FLIT_W-1:0]          out_flit,
  output logic                       out_valid,
  input  logic                       out_ready,
  input  logic                       cfg_we,
  input  logic [$clog2(MAX_DEST)-1:0] cfg_idx,
  input  logic [3:0]                 cfg_dest,
  input  logic                       cfg_vc,
  input  logic [$clog2(MAX_DEST):0]  cfg_num,
  output logic                       busy,
  output logic                       err_timeout
);

  localparam int IW = $clog2(MAX_DEST);
  localparam int TW = $clog2(TIMEOUT + 1);

  state_t               state_q, state_d;
  logic                 have_a_q, have_b_q;
  logic [PAYLOAD_W-1:0] op_a_q, op_b_q, res_q;
  logic [IW-1:0]        idx_q;
  logic [TW-1:0]        wcnt_q;
  logic                 err_q;

  logic                 in_v, in_d, in_vc;
  logic [PAYLOAD_W-1:0] in_pl;
  logic                 accept, acc_a, acc_b, pair;
  logic                 last, tmo, leave;
  logic [3:0]           rd_dest;
  logic                 rd_vc;
  logic [IW:0]          num_dest;
  logic                 unused_ok;
  flit_t                of;

  assign in_v      = in_flit[VALID_B];
  assign in_d      = in_flit[DATA_B];
  assign in_vc     = in_flit[VC_B];
  assign in_pl     = in_flit[PAYLOAD_W-1:0];
  assign unused_ok = ^in_flit[DEST_HI:DEST_LO];

  assign accept = in_v & in_d & in_ready;
  assign acc_a  = accept & ~in_vc;
  assign acc_b  = accept & in_vc;
  assign pair   = (have_a_q | acc_a) & (have_b_q | acc_b);
  assign last   = ({1'b0, idx_q} == num_dest - 1'b1);
  assign tmo    = (state_q == WAIT) & ~pe_done &
                  (wcnt_q == TW'(TIMEOUT - 1));
  assign leave  = (state_q != COLLECT) & (state_d == COLLECT);

  pe_dest_table #(
    .MAX_DEST (MAX_DEST)
  ) u_table (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (state_q == COLLECT),
    .cfg_we   (cfg_we),
    .cfg_idx  (cfg_idx),
    .cfg_dest (cfg_dest),
    .cfg_vc   (cfg_vc),
    .cfg_num  (cfg_num),
    .rd_idx   (idx_q),
    .rd_dest  (rd_dest),
    .rd_vc    (rd_vc),
    .num_dest (num_dest)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      COLLECT: if (pair) state_d = EXEC;
      EXEC:    state_d = WAIT;
      WAIT: begin
        if (pe_done)  state_d = SEND;
        else if (tmo) state_d = COLLECT;
      end
      SEND: if (out_ready && last) state_d = COLLECT;
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= COLLECT;
      have_a_q <= 1'b0;
      have_b_q <= 1'b0;
      op_a_q   <= '0;
      op_b_q   <= '0;
      res_q    <= '0;
      idx_q    <= '0;
      wcnt_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= tmo;
      if (leave) begin
        have_a_q <= 1'b0;
        have_b_q <= 1'b0;
      end else begin
        if (acc_a) begin
          op_a_q   <= in_pl;
          have_a_q <= 1'b1;
        end
        if (acc_b) begin
          op_b_q   <= in_pl;
          have_b_q <= 1'b1;
        end
      end
      wcnt_q <= (state_q == WAIT) ? wcnt_q + 1'b1 : '0;
      if (state_q == WAIT && pe_done) begin
        res_q <= pe_result;
        idx_q <= '0;
      end
      // Wrap idx on the final handshake so the next fan-out starts at 0.
      if (state_q == SEND && out_ready)
        idx_q <= last ? '0 : idx_q + 1'b1;
    end
  end

  always_comb begin
    of         = '0;
    of.valid   = 1'b1;
    of.data    = 1'b1;
    of.dest    = rd_dest;
    of.vc      = rd_vc;
    of.payload = res_q;
  end

  assign in_ready    = (state_q == COLLECT) & ~rst;
  assign pe_start    = (state_q == EXEC);
  assign busy        = (state_q != COLLECT);
  assign out_valid   = (state_q == SEND);
  assign out_flit    = out_valid ? of : '0;
  assign pe_op_a     = op_a_q;
  assign pe_op_b     = op_b_q;
  assign err_timeout = err_q;

endmodule

// File: tb/tb_pe_dispatch_ctrl.sv
// Randomized bench for pe_dispatch_ctrl against a transaction-level
// model of operand pairing, table fan-out and timeout.
module tb_pe_dispatch_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic [70:0]  in_flit;
  logic         in_ready;
  logic [63:0]  pe_op_a, pe_op_b, pe_result;
  logic         pe_start, pe_done;
  logic [70:0]  out_flit;
  logic         out_valid, out_ready;
  logic         cfg_we, cfg_vc;
  logic [1:0]   cfg_idx;
  logic [3:0]   cfg_dest;
  logic [2:0]   cfg_num;
  logic         busy, err_timeout;

  always #5 clk = ~clk;

  pe_dispatch_ctrl #(
    .MAX_DEST (4),
    .TIMEOUT  (255)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_flit     (in_flit),
    .in_ready    (in_ready),
    .pe_op_a     (pe_op_a),
    .pe_op_b     (pe_op_b),
    .pe_start    (pe_start),
    .pe_result   (pe_result),
    .pe_done     (pe_done),
    .out_flit    (out_flit),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .cfg_we      (cfg_we),
    .cfg_idx     (cfg_idx),
    .cfg_dest    (cfg_dest),
    .cfg_vc      (cfg_vc),
    .cfg_num     (cfg_num),
    .busy        (busy),
    .err_timeout (err_timeout)
  );

  int errors = 0;
  int checks = 0;

  logic [3:0]  m_dest [4];
  logic        m_vc   [4];
  int          m_num;
  logic [63:0] m_a, m_b;
  bit          ha, hb;

  task automatic check(input string tag,
                       input logic [127:0] got,
                       input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_dest[i] = 4'b0101;
      m_vc[i]   = 1'b0;
    end
    m_num = 1;
    m_a = '0;
    m_b = '0;
    ha = 0;
    hb = 0;
  endtask

  task automatic model_cfg(input logic [1:0] idx, input logic [3:0] d,
                           input logic v, input logic [2:0] n);
    m_dest[idx] = d;
    m_vc[idx]   = v;
    if (n >= 3'd1 && n <= 3'd4) m_num = int'(n);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    in_flit = '0;
    pe_done = 1'b0;
    out_ready = 1'b0;
    cfg_we = 1'b0;
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_flit", out_flit, 0);
    check("rst_pe_start", pe_start, 0);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_err", err_timeout, 0);
    check("rst_op_a", pe_op_a, 0);
    check("rst_op_b", pe_op_b, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    model_reset();
    check("post_rst_in_ready", in_ready, 1);
    check("post_rst_busy", busy, 0);
    check("post_rst_out_valid", out_valid, 0);
  endtask

  task automatic cfg_write(input logic [1:0] idx, input logic [3:0] d,
                           input logic v, input logic [2:0] n);
    check("cfg_in_collect", in_ready, 1);
    cfg_we = 1'b1;
    cfg_idx = idx;
    cfg_dest = d;
    cfg_vc = v;
    cfg_num = n;
    model_cfg(idx, d, v, n);
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic put_flit(input logic v, input logic d, input logic vc,
                          input logic [63:0] p, input bit noise);
    check("in_ready", in_ready, 1);
    in_flit = {v, d, 4'($urandom), vc, p};
    if (noise) begin
      pe_done = 1'($urandom);
      pe_result = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) begin
        cfg_we = 1'b1;
        cfg_idx = 2'($urandom);
        cfg_dest = 4'($urandom);
        cfg_vc = 1'($urandom);
        cfg_num = 3'($urandom);
        model_cfg(cfg_idx, cfg_dest, cfg_vc, cfg_num);
      end
    end
    @(negedge clk);
    if (v && d) begin
      if (vc) begin m_b = p; hb = 1; end
      else begin m_a = p; ha = 1; end
    end
    in_flit = '0;
    cfg_we = 1'b0;
    pe_done = 1'b0;
  endtask

  task automatic feed_random();
    int it;
    logic v, d, vc;
    it = 0;
    while (!(ha && hb)) begin
      v = ($urandom_range(0, 9) != 0);
      d = ($urandom_range(0, 9) != 0);
      vc = 1'($urandom);
      if (it >= 6) begin
        v = 1'b1;
        d = 1'b1;
        vc = ha;
      end
      put_flit(v, d, vc, {$urandom, $urandom}, 1);
      it++;
    end
  endtask

  // lat < 0 means no pe_done at all (timeout path)
  task automatic exec_wait(input int lat, input logic [63:0] r,
                           input int stall0, input bit rnd,
                           input bit rst_send);
    int i, cyc, st;
    check("exec_pe_start", pe_start, 1);
    check("exec_op_a", pe_op_a, m_a);
    check("exec_op_b", pe_op_b, m_b);
    check("exec_busy", busy, 1);
    check("exec_in_ready", in_ready, 0);
    pe_done = 1'b1;
    pe_result = ~r;
    @(negedge clk);
    pe_done = 1'b0;
    check("wait_pe_start", pe_start, 0);
    check("wait_op_a", pe_op_a, m_a);
    check("wait_op_b", pe_op_b, m_b);
    if (lat < 0) begin
      repeat (254) @(negedge clk);
      check("tmo_early_err", err_timeout, 0);
      check("tmo_early_busy", busy, 1);
      check("tmo_early_valid", out_valid, 0);
      @(negedge clk);
      check("tmo_err", err_timeout, 1);
      check("tmo_in_ready", in_ready, 1);
      check("tmo_busy", busy, 0);
      check("tmo_valid", out_valid, 0);
      @(negedge clk);
      check("tmo_err_pulse", err_timeout, 0);
      ha = 0;
      hb = 0;
      return;
    end
    repeat (lat) @(negedge clk);
    check("wait_no_valid", out_valid, 0);
    pe_done = 1'b1;
    pe_result = r;
    @(negedge clk);
    pe_done = 1'b0;
    if (rst_send) begin
      check("send_valid_pre_rst", out_valid, 1);
      rst = 1'b1;
      @(negedge clk);
      check("rst_send_valid", out_valid, 0);
      check("rst_send_flit", out_flit, 0);
      check("rst_send_in_ready", in_ready, 0);
      rst = 1'b0;
      #1;
      model_reset();
      check("rst_send_busy", busy, 0);
      check("rst_send_ready", in_ready, 1);
      return;
    end
    i = 0;
    cyc = 0;
    st = 0;
    while (i < m_num && cyc < 64) begin
      check("send_valid", out_valid, 1);
      check("send_flit", out_flit, {2'b11, m_dest[i], m_vc[i], r});
      if (rnd) out_ready = (st >= 2) || ($urandom_range(0, 1) == 1);
      else out_ready = (cyc >= stall0);
      st = out_ready ? 0 : st + 1;
      cfg_we = 1'($urandom);
      cfg_idx = 2'($urandom);
      cfg_dest = 4'($urandom);
      cfg_vc = 1'($urandom);
      cfg_num = 3'($urandom);
      pe_done = 1'($urandom);
      pe_result = {$urandom, $urandom};
      @(negedge clk);
      if (out_ready) i++;
      cyc++;
      out_ready = 1'b0;
      cfg_we = 1'b0;
      pe_done = 1'b0;
    end
    if (i < m_num) check("send_bound", i, m_num);
    check("done_valid", out_valid, 0);
    check("done_in_ready", in_ready, 1);
    check("done_busy", busy, 0);
    ha = 0;
    hb = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    in_flit = '0;
    pe_result = '0;
    pe_done = 1'b0;
    out_ready = 1'b0;
    cfg_we = 1'b0;
    cfg_idx = '0;
    cfg_dest = '0;
    cfg_vc = 1'b0;
    cfg_num = '0;
    apply_reset();

    put_flit(1, 1, 0, 64'd6, 0);
    put_flit(1, 1, 1, 64'hF, 0);
    exec_wait(3, 64'd6, 0, 0, 0);

    cfg_write(2'd0, 4'd2, 1'b0, 3'd3);
    cfg_write(2'd1, 4'd7, 1'b1, 3'd3);
    cfg_write(2'd2, 4'd9, 1'b0, 3'd3);
    put_flit(1, 1, 0, 64'h11, 0);
    put_flit(1, 1, 1, 64'h22, 0);
    exec_wait(2, 64'hAA, 2, 0, 0);

    put_flit(1, 1, 0, 64'd5, 0);
    put_flit(0, 1, 1, 64'd99, 0);
    put_flit(1, 1, 0, 64'd3, 0);
    put_flit(1, 0, 1, 64'd77, 0);
    put_flit(1, 1, 1, 64'd1, 0);
    check("op_a_latest", pe_op_a, 64'd3);
    exec_wait(0, 64'h1234, 0, 0, 0);

    feed_random();
    exec_wait(254, {$urandom, $urandom}, 0, 1, 0);

    feed_random();
    exec_wait(-1, '0, 0, 0, 0);

    feed_random();
    exec_wait(1, {$urandom, $urandom}, 0, 0, 1);

    cfg_write(2'd0, 4'b0101, 1'b0, 3'd0);
    feed_random();
    exec_wait(4, {$urandom, $urandom}, 0, 0, 0);

    cfg_write(2'd3, 4'b0101, 1'b0, 3'd4);
    feed_random();
    exec_wait(0, {$urandom, $urandom}, 0, 1, 0);

    repeat (25) begin
      if ($urandom_range(0, 1) == 1)
        cfg_write(2'($urandom), 4'($urandom), 1'($urandom),
                  3'($urandom));
      feed_random();
      exec_wait($urandom_range(0, 12), {$urandom, $urandom}, 0, 1, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pe_dispatch_ctrl.md
# pe_dispatch_ctrl

Sequencing controller between a router local port and a two-operand processing element (AND/OR/ADD style).
- Collects operand A and operand B from incoming 71-bit flits and starts the PE once per operand pair.
- Waits for the PE result, then fans the result out as one flit per entry of a runtime-programmable destination table, under output backpressure.
- Replaces per-PE hard-coded destination arrays and repeat counters.

## Interface
Parameters:
- MAX_DEST, 4: destination table depth (index width 2).
- TIMEOUT, 255: maximum cycles spent in WAIT before abort.

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- in_flit  in  71  {valid[70], data[69], dest[68:65], vc[64], payload[63:0]}
- in_ready  out  1  high only in COLLECT
- pe_op_a  out  64  operand A to PE
- pe_op_b  out  64  operand B to PE
- pe_start  out  1  one-cycle start pulse
- pe_result  in  64  PE result
- pe_done  in  1  result valid strobe
- out_flit  out  71  result flit to router
- out_valid  out  1  out_flit valid
- out_ready  in  1  router accepts out_flit
- cfg_we  in  1  configuration write strobe
- cfg_idx  in  2  table entry to write
- cfg_dest  in  4  destination node id
- cfg_vc  in  1  destination vc
- cfg_num  in  3  active entry count, legal 1..4
- busy  out  1  state != COLLECT
- err_timeout  out  1  one-cycle pulse on WAIT timeout

## Operation
- Accept rule: in_flit[70] & in_flit[69] & in_ready. vc bit 0 stores operand A and sets have_a; vc bit 1 stores operand B and sets have_b. A repeated operand overwrites the stored value (latest wins).
- COLLECT: on the edge where have_a and have_b become both set, go to EXEC.
- EXEC: pe_start=1 for exactly one cycle, then go to WAIT. pe_op_a and pe_op_b are stable from EXEC until leaving WAIT.
- WAIT: pe_done is sampled only here; pe_done in other states is ignored.
  - On pe_done: latch pe_result, set idx=0, go to SEND.
  - After TIMEOUT cycles in WAIT without pe_done: pulse err_timeout, clear have flags, go to COLLECT.
- SEND: out_valid=1, out_flit={1,1,dest[idx],vc[idx],result}.
  - On out_ready with idx==num_dest-1: clear have flags, go to COLLECT.
  - On out_ready otherwise: idx+1, stay in SEND.
- Config:
  - cfg_we is honoured only in COLLECT; in any other state the write is dropped.
  - A write stores table[cfg_idx]={cfg_dest,cfg_vc}.
  - num_dest is updated from cfg_num only if cfg_num is 1..4; otherwise num_dest is unchanged.
  - A write in the same cycle as a second-operand accept is honoured.
- Reset, applied mid-operation or otherwise: state COLLECT, have flags 0, idx 0, num_dest 1, every table entry dest 4'b0101/vc 0, stored operands and result 0.

## Timing
- All outputs are registered or decoded from the registered state. Values while rst is high and in the first cycle after:
  - out_valid=0, out_flit=0, pe_start=0, pe_op_a/b=0, busy=0, err_timeout=0.
  - in_ready=0 while rst is high; in_ready=1 from the first cycle after rst deasserts.
- Second operand accepted at edge N: pe_start high during cycle N+1, WAIT from N+2.
- pe_done sampled at edge M: out_valid high in cycle M+1.
- out_flit is held stable while out_valid & !out_ready.
- One flit per cycle under continuous out_ready; a 4-entry fan-out takes 4 cycles.
- in_ready is low from EXEC through the final SEND handshake. The first accept after that is possible in the cycle following the final out_ready edge.

## Structure
- Shared package pe_pkg holds:
  - flit field positions: VALID_B=70, DATA_B=69, DEST_HI=68, DEST_LO=65, VC_B=64, PAYLOAD_W=64, FLIT_W=71;
  - the flit struct typedef;
  - the state enum {COLLECT, EXEC, WAIT, SEND};
  - DEFAULT_DEST=4'b0101.
- One sub-module, pe_dest_table: the 4-entry destination table with num_dest register and write-enable gating. The FSM, operand registers and timeout counter stay in the top level.

## Test plan
- Reset, then flit vc0 payload 6, then flit vc1 payload 0xF, PE returns 6, out_ready=1 -> pe_start one cycle with op_a=6, op_b=0xF; one out_flit {1,1,0101,0,6}; back to COLLECT.
- Program num_dest=3, entries 2/0, 7/1, 9/0; result 0xAA; out_ready low for 2 cycles, then high -> three flits in order 2, 7, 9 with matching vc; out_flit held constant while stalled.
- Two vc0 flits (5, then 3), then vc1 flit 1 -> pe_op_a=3; invalid flit (bit70=0) ignored.
- No pe_done for 255 WAIT cycles -> err_timeout pulse; in_ready high the next cycle; no out_valid.
- cfg_we during SEND, and cfg_num=0 in COLLECT -> both writes have no effect (num_dest stays 1); rst asserted mid-SEND -> out_valid=0 the next cycle and table restored to 0101/0.
